mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter and sequencer for the five-stage pipeline. It shares one unified instruction/data memory between the IF-stage fetch port and the MEM-stage data port. The data port carries LOAD/STORE requests from the control-unit `mem_en`/`rw` signals. The block runs a fixed-latency memory transaction FSM, raises per-port stall signals, and applies a bounded-starvation priority rule.

## Interface
- `ADDR_W`, 16, address width for both ports and memory
- `DATA_W`, 16, data width
- `MEM_LATENCY`, 2, number of WAIT cycles from issue to read data valid; must be ≥1
- `STREAK_MAX`, 4, maximum consecutive data grants while a fetch is pending; must be ≥1

Ports:
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `if_req` in 1, fetch request; held with `if_addr` until `if_ack`
- `if_addr` in ADDR_W, fetch address
- `if_ack` out 1, one-cycle fetch completion pulse
- `if_rdata` out DATA_W, fetched word
- `if_stall` out 1, `if_req & ~if_ack` (combinational)
- `dm_req` in 1, data request (MEM-stage `mem_en`); held until `dm_ack`
- `dm_rw` in 1, 1 = read (LOAD), 0 = write (STORE)
- `dm_addr` in ADDR_W, data address
- `dm_wdata` in DATA_W, store data
- `dm_ack` out 1, one-cycle data completion pulse
- `dm_rdata` out DATA_W, load result
- `dm_stall` out 1, `dm_req & ~dm_ack` (combinational)
- `mem_en` out 1, one-cycle issue strobe to memory
- `mem_rw` out 1, 1 = read, 0 = write
- `mem_addr` out ADDR_W, memory address
- `mem_wdata` out DATA_W, memory write data
- `mem_rdata` in DATA_W, memory read data, valid in the last WAIT cycle

## Operation
- FSM states: IDLE, WAIT, RESP. One transaction is in flight at a time. Requests are sampled only in IDLE.
- In IDLE, with any request present, the FSM selects a winner and moves to WAIT. On that edge it latches `mem_rw`, `mem_addr` and `mem_wdata` (reads drive `mem_wdata` = 0), sets `mem_en`, and loads the wait counter with `MEM_LATENCY`.
- The fetch port always issues a read (`mem_rw` = 1). The data port issues `mem_rw` = `dm_rw`.
- In WAIT:
  - `mem_en` is high only in the first WAIT cycle.
  - `mem_*` address and data outputs stay stable for the whole of WAIT.
  - The counter decrements each cycle. On the edge where it equals 1, the FSM moves to RESP.
  - On that same edge, `mem_rdata` is captured into `if_rdata` (fetch) or `dm_rdata` (data read only).
- In RESP, the winner's ack is high for exactly one cycle. Requests present in RESP are ignored. The FSM returns to IDLE on the next edge.
- Priority: the data port wins over fetch, unless `if_req` = 1 and the streak counter equals `STREAK_MAX`. In that case fetch wins.
- Streak counter (saturating at `STREAK_MAX`):
  - increments on a data grant while `if_req` = 1;
  - clears on a data grant while `if_req` = 0;
  - clears on any fetch grant.
- Output hold rules:
  - `dm_rdata` is not updated by stores.
  - Both rdata registers hold their value until the next qualifying capture.
- Reset values: state IDLE, counters 0, `if_ack`/`dm_ack`/`mem_en`/`mem_rw` = 0, and all address/data outputs = 0.
- Reset asserted mid-transaction (WAIT or RESP) abandons the transaction immediately: no ack is produced. A request still held after `rst` falls is re-arbitrated and re-issued from IDLE.

## Timing
- Request seen in IDLE in cycle t:
  - `mem_en` in cycle t+1;
  - WAIT occupies cycles t+1 .. t+MEM_LATENCY;
  - `mem_rdata` is sampled at the end of cycle t+MEM_LATENCY;
  - ack is high in cycle t+MEM_LATENCY+1;
  - the FSM is back in IDLE in cycle t+MEM_LATENCY+2.
- Occupancy per transaction is `MEM_LATENCY`+2 cycles. The next issue happens at the earliest in cycle t+MEM_LATENCY+3.
- A requester observing ack treats its request as done at that edge. Any `req` level in the following IDLE cycle is a new request.
- Simultaneous `if_req` and `dm_req` in IDLE: one grant only, per the priority rule. The loser stalls through the full transaction.
- Stall outputs are combinational. Ack and all `mem_*` outputs are registered.

## Test plan
- Fetch: `if_req` = 1, `if_addr` = 0x0010, `mem_rdata` = 0xA5A5 in cycle t+2 (L=2) -> `mem_en` and `mem_rw` = 1 with `mem_addr` = 0x0010 in cycle t+1; `if_ack` = 1 and `if_rdata` = 0xA5A5 in cycle t+3; `if_stall` = 1 in cycles t..t+2.
- Store: `dm_req` = 1, `dm_rw` = 0, `dm_addr` = 0x0200, `dm_wdata` = 0x1234 -> `mem_rw` = 0, `mem_addr` = 0x0200, `mem_wdata` = 0x1234 stable in cycles t+1..t+2; `dm_ack` in cycle t+3; `dm_rdata` unchanged.
- Simultaneous fetch and load in cycle t (streak 0) -> data ack in cycle t+3; fetch issued in cycle t+5; `if_ack` in cycle t+7.
- Starvation: `if_req` held high and `dm_req` re-raised every IDLE cycle -> grants are data ×4, then fetch, then data again (streak cleared).
- Load data: load 0x0300 returns 0xBEEF, then store -> `dm_rdata` = 0xBEEF persists after the store ack.
- Reset: `rst` pulsed in cycle t+1 of a fetch -> `mem_en` = 0 and state IDLE immediately; no `if_ack` for that transaction; the fetch re-issues 1 cycle after `rst` falls and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one unified memory between the IF fetch port and
// the MEM data port. It runs one fixed-latency transaction at a time and bounds fetch starvation.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2,
    parameter int STREAK_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     streak_q;
    logic              sel_if_q;
    logic              if_ack_q, dm_ack_q, mem_en_q, mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

    logic any_req, pick_if, streak_full;

    always_comb begin
        streak_full = (streak_q == SW'(STREAK_MAX));
        any_req     = if_req | dm_req;
        // Data wins by default; a pending fetch wins once the data streak has saturated.
        pick_if     = if_req & (~dm_req | streak_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            sel_if_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q  <= WAIT;
                        mem_en_q <= 1'b1;
                        cnt_q    <= CW'(MEM_LATENCY);
                        sel_if_q <= pick_if;
                        if (pick_if) begin
                            mem_rw_q    <= 1'b1;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            streak_q    <= '0;
                        end else begin
                            mem_rw_q    <= dm_rw;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_rw ? '0 : dm_wdata;
                            if (!if_req)
                                streak_q <= '0;
                            else if (!streak_full)
                                streak_q <= streak_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    mem_en_q <= 1'b0;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                        if (sel_if_q) begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            dm_ack_q <= 1'b1;
                            if (mem_rw_q)
                                dm_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

endmodule
